// File: rtl/neuro_pkg.sv
// neuro_pkg: Q-format constants, accumulator FSM states and a saturation helper shared by the neuron datapath.
package neuro_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W = 40;
  localparam int Q_ONE = 1 << FRAC_W;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FINISH} state_t;
  function automatic logic [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] q_max, q_min;
    q_max = ACC_W'(2 ** (DATA_W - 1) - 1);
    q_min = ~q_max;
    return x > q_max ? q_max[DATA_W-1:0] : x < q_min ? q_min[DATA_W-1:0] : x[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/q_saturate.sv
// q_saturate: rescales a Q accumulator to Q format, adds the bias and clips to DATA_W with a clip flag.
module q_saturate #(
  parameter int DATA_W = neuro_pkg::DATA_W,
  parameter int FRAC_W = neuro_pkg::FRAC_W,
  parameter int ACC_W = neuro_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0]        val_o,
  output logic                     sat_o
);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;
  logic signed [ACC_W:0] sh, bs, t;
  logic hi, lo;
  // One guard bit so the bias add can never wrap before the clip.
  assign sh = {acc_i[ACC_W-1], acc_i >>> FRAC_W};
  assign bs = {{(ACC_W + 1 - DATA_W){bias_i[DATA_W-1]}}, bias_i};
  assign t = sh + bs;
  assign hi = t > MAXV;
  assign lo = t < MINV;
  assign val_o = hi ? MAXV[DATA_W-1:0] : lo ? MINV[DATA_W-1:0] : t[DATA_W-1:0];
  assign sat_o = hi | lo;
endmodule

// File: rtl/neuron_accumulate.sv
// neuron_accumulate: MAC over a beat stream, adds bias, saturates, optional ReLU, and writes one result per neuron.
module neuron_accumulate #(
  parameter int DATA_W = neuro_pkg::DATA_W,
  parameter int FRAC_W = neuro_pkg::FRAC_W,
  parameter int ACC_W = neuro_pkg::ACC_W,
  parameter int ACT_RELU = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_adds,
  input  logic [15:0]       neuron_idx,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] in_val,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_we,
  output logic              busy,
  output logic [15:0]       result_addr,
  output logic [DATA_W-1:0] result_val,
  output logic              result_we,
  output logic              done,
  output logic              sat_flag
);
  import neuro_pkg::*;
  state_t state_q, state_d;
  logic [15:0] cnt_q, num_q, idx_q;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [2*DATA_W-1:0] prod_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DATA_W-1:0] sat_v, rval_q;
  logic pv_q, pend_q, rsat_q, sat_c, accept, wr;
  assign accept = state_q == ACCUM && in_we && !start;
  assign wr = pend_q && !start;
  assign busy = state_q != IDLE || pend_q;
  always_comb begin
    state_d = start ? (num_adds == '0 ? DRAIN : ACCUM)
            : state_q == ACCUM ? (accept && cnt_q + 16'd1 == num_q ? DRAIN : ACCUM)
            : state_q == DRAIN ? FINISH : IDLE;
  end
  q_saturate #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_sat (
    .acc_i(acc_q), .bias_i(bias_q), .val_o(sat_v), .sat_o(sat_c)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      num_q <= '0;
      idx_q <= '0;
      bias_q <= '0;
      prod_q <= '0;
      acc_q <= '0;
      pv_q <= 1'b0;
      pend_q <= 1'b0;
      rval_q <= '0;
      rsat_q <= 1'b0;
      result_addr <= '0;
      result_val <= '0;
      result_we <= 1'b0;
      done <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q <= accept;
      if (accept) prod_q <= (2 * DATA_W)'($signed(in_val)) * (2 * DATA_W)'($signed(in_weight));
      if (start) begin
        num_q <= num_adds;
        idx_q <= neuron_idx;
        bias_q <= bias;
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        if (accept) cnt_q <= cnt_q + 16'd1;
        if (pv_q) acc_q <= acc_q + ACC_W'(prod_q);
      end
      // Result is staged one cycle after FINISH so the write lands 3 cycles after the last beat.
      pend_q <= state_q == FINISH && !start;
      rval_q <= (ACT_RELU != 0 && sat_v[DATA_W-1]) ? '0 : sat_v;
      rsat_q <= sat_c;
      result_we <= wr;
      done <= wr;
      if (wr) begin
        result_val <= rval_q;
        result_addr <= idx_q;
      end
      sat_flag <= start ? 1'b0 : sat_flag | (wr & rsat_q);
    end
  end
endmodule

// File: tb/tb_neuron_accumulate.sv
// tb_neuron_accumulate: table-driven vectors for a ReLU and a linear instance, plus reset/restart sequences.
module tb_neuron_accumulate;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_we = 1'b0;
  logic [15:0] num_adds = '0, neuron_idx = '0, bias = '0, in_val = '0, in_weight = '0;
  logic busy, result_we, done, sat_flag, b0, we0, d0, s0;
  logic [15:0] result_addr, result_val, a0, v0;
  int cyc = 0, total = 0, bad = 0, we_cnt = 0, we_cyc = 0;
  logic [15:0] cap_val, cap_v0, cap_addr;
  logic cap_sat, cap_done;

  typedef struct {
    int num;
    logic [15:0] bias, idx;
    int nb;
    bit gap;
    logic [0:5][15:0] v, w;
    logic [15:0] e1, e0;
    bit es;
  } vec_t;
  vec_t tv[7];

  neuron_accumulate dut (
    .clk(clk), .rst(rst), .start(start), .num_adds(num_adds), .neuron_idx(neuron_idx), .bias(bias),
    .in_val(in_val), .in_weight(in_weight), .in_we(in_we), .busy(busy), .result_addr(result_addr),
    .result_val(result_val), .result_we(result_we), .done(done), .sat_flag(sat_flag)
  );
  neuron_accumulate #(.ACT_RELU(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .num_adds(num_adds), .neuron_idx(neuron_idx), .bias(bias),
    .in_val(in_val), .in_weight(in_weight), .in_we(in_we), .busy(b0), .result_addr(a0),
    .result_val(v0), .result_we(we0), .done(d0), .sat_flag(s0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (result_we) begin
    we_cnt++;
    we_cyc = cyc;
    cap_val = result_val;
    cap_v0 = v0;
    cap_addr = result_addr;
    cap_sat = sat_flag;
    cap_done = done;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input int num, input logic [15:0] b, input logic [15:0] idx, input int nb,
                              input bit gap, input logic [0:5][15:0] v, input logic [0:5][15:0] w,
                              input logic [15:0] e1, input logic [15:0] e0, input bit es);
    vec_t t;
    t.num = num; t.bias = b; t.idx = idx; t.nb = nb; t.gap = gap;
    t.v = v; t.w = w; t.e1 = e1; t.e0 = e0; t.es = es;
    return t;
  endfunction

  task automatic run(input int i, input vec_t t);
    int last;
    @(negedge clk);
    we_cnt = 0;
    start = 1'b1;
    num_adds = t.num[15:0];
    bias = t.bias;
    neuron_idx = t.idx;
    @(negedge clk);
    start = 1'b0;
    last = cyc;
    for (int j = 0; j < t.nb; j++) begin
      if (t.gap) begin
        in_we = 1'b0;
        @(negedge clk);
      end
      in_we = 1'b1;
      in_val = t.v[j];
      in_weight = t.w[j];
      @(negedge clk);
      if (j == t.num - 1) last = cyc;
    end
    in_we = 1'b0;
    repeat (8) @(negedge clk);
    chk($sformatf("v%0d_wecnt", i), we_cnt, 1);
    chk($sformatf("v%0d_latency", i), we_cyc - last, 3);
    chk($sformatf("v%0d_val_relu", i), cap_val, t.e1);
    chk($sformatf("v%0d_val_lin", i), cap_v0, t.e0);
    chk($sformatf("v%0d_addr", i), cap_addr, t.idx);
    chk($sformatf("v%0d_sat", i), cap_sat, t.es);
    chk($sformatf("v%0d_done", i), cap_done, 1);
    chk($sformatf("v%0d_idle", i), busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", result_we, 0);
    chk("rst_done", done, 0);
    chk("rst_val", result_val, 0);
    chk("rst_addr", result_addr, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tv[0] = mk(3, 16'h0000, 16'h0055, 3, 0, {16'h0100, 16'h0200, 16'hFF00, 48'h0},
               {16'h0100, 16'h0100, 16'h0100, 48'h0}, 16'h0200, 16'h0200, 0);
    tv[1] = mk(2, 16'h0000, 16'h0021, 2, 0, {16'h7F00, 16'h7F00, 64'h0},
               {16'h7F00, 16'h7F00, 64'h0}, 16'h7FFF, 16'h7FFF, 1);
    tv[2] = mk(1, 16'h0000, 16'h0031, 1, 0, {16'hFF00, 80'h0}, {16'h0200, 80'h0}, 16'h0000, 16'hFE00, 0);
    tv[3] = mk(0, 16'h0180, 16'h0041, 0, 0, 96'h0, 96'h0, 16'h0180, 16'h0180, 0);
    tv[4] = mk(4, 16'h0010, 16'h0051, 6, 1,
               {16'h0100, 16'h0100, 16'h0300, 16'h0080, 16'h7F00, 16'h7F00},
               {16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h7F00, 16'h7F00}, 16'h0710, 16'h0710, 0);
    tv[5] = mk(1, 16'h0000, 16'h0061, 1, 0, {16'h8000, 80'h0}, {16'h7FFF, 80'h0}, 16'h0000, 16'h8000, 1);
    tv[6] = mk(1, 16'h0002, 16'h0071, 1, 0, {16'hFFFF, 80'h0}, {16'h0001, 80'h0}, 16'h0001, 16'h0001, 0);
    for (int i = 0; i < 7; i++) run(i, tv[i]);

    // Reset in the middle of accumulation abandons the neuron.
    @(negedge clk);
    we_cnt = 0;
    start = 1'b1; num_adds = 16'd4; neuron_idx = 16'h0099; bias = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    in_we = 1'b1; in_val = 16'h0100; in_weight = 16'h0100;
    repeat (2) @(negedge clk);
    in_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_val", result_val, 0);
    chk("midrst_addr", result_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sat", sat_flag, 0);
    repeat (8) @(negedge clk);
    chk("midrst_wecnt", we_cnt, 0);

    // Restart mid-accumulation; the beat coincident with the restart is ignored.
    we_cnt = 0;
    start = 1'b1; num_adds = 16'd3; neuron_idx = 16'h0011; bias = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    in_we = 1'b1; in_val = 16'h0100; in_weight = 16'h0100;
    repeat (2) @(negedge clk);
    chk("restart_busy", busy, 1);
    start = 1'b1; num_adds = 16'd2; neuron_idx = 16'h0022;
    in_val = 16'h7F00; in_weight = 16'h7F00;
    @(negedge clk);
    start = 1'b0;
    in_val = 16'h0100; in_weight = 16'h0300;
    @(negedge clk);
    in_val = 16'h0100; in_weight = 16'h0100;
    @(negedge clk);
    in_we = 1'b0;
    repeat (8) @(negedge clk);
    chk("restart_wecnt", we_cnt, 1);
    chk("restart_addr", cap_addr, 16'h0022);
    chk("restart_val", cap_val, 16'h0400);
    chk("restart_sat", cap_sat, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
